// File: rtl/regfile_reader.sv
// Register-array read port with busy scoreboard, writeback bypass and a
// one-entry registered output stage under valid/ready handshakes.
module regfile_reader #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] regs [NREG],
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AW-1:0]     req_rs,
   input  logic [AW-1:0]     req_rt,
   input  logic              req_dst_en,
   input  logic [AW-1:0]     req_dst,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic              out_dst_en,
   output logic [AW-1:0]     out_dst,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [NREG-1:0]   busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_rs_q, out_rs_d;
   logic [DATA_W-1:0] out_rt_q, out_rt_d;
   logic              out_dst_en_q, out_dst_en_d;
   logic [AW-1:0]     out_dst_q, out_dst_d;
   logic [CNT_W-1:0]  stall_q, stall_d;

   logic rs_zero, rt_zero, hit_rs, hit_rt, haz_rs, haz_rt, hazard, accept;
   logic [DATA_W-1:0] rs_data, rt_data;

   always_comb begin
      rs_zero = (req_rs == '0);
      rt_zero = (req_rt == '0);
      hit_rs  = wb_en && (wb_addr == req_rs) && !rs_zero;
      hit_rt  = wb_en && (wb_addr == req_rt) && !rt_zero;
      // Hazard looks at the scoreboard as it stood before this edge.
      haz_rs  = busy_q[req_rs] && !rs_zero && !hit_rs;
      haz_rt  = busy_q[req_rt] && !rt_zero && !hit_rt;
      hazard  = haz_rs || haz_rt;
      req_ready = rst_n && !hazard && (!out_valid_q || out_ready);
      accept  = req_valid && req_ready;

      rs_data = rs_zero ? '0 : (hit_rs ? wb_data : regs[req_rs]);
      rt_data = rt_zero ? '0 : (hit_rt ? wb_data : regs[req_rt]);
   end

   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_addr] = 1'b0;
      end
      // Set after clear: a new producer on the same index stays pending.
      if (accept && req_dst_en && (req_dst != '0)) begin
         busy_d[req_dst] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_rs_d     = out_rs_q;
      out_rt_d     = out_rt_q;
      out_dst_en_d = out_dst_en_q;
      out_dst_d    = out_dst_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_rs_d     = rs_data;
         out_rt_d     = rt_data;
         out_dst_en_d = req_dst_en;
         out_dst_d    = req_dst;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (req_valid && !req_ready && (stall_q != CntMax)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q       <= '0;
         out_valid_q  <= 1'b0;
         out_rs_q     <= '0;
         out_rt_q     <= '0;
         out_dst_en_q <= 1'b0;
         out_dst_q    <= '0;
         stall_q      <= '0;
      end else begin
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
         out_rs_q     <= out_rs_d;
         out_rt_q     <= out_rt_d;
         out_dst_en_q <= out_dst_en_d;
         out_dst_q    <= out_dst_d;
         stall_q      <= stall_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_rs_data = out_rs_q;
   assign out_rt_data = out_rt_q;
   assign out_dst_en  = out_dst_en_q;
   assign out_dst     = out_dst_q;
   assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: reads, r0, hazard/bypass, backpressure,
// set/clear collision, counter saturation and mid-operation reset.
module tb_regfile_reader;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned AW     = 5;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] regs [NREG];
   logic              req_valid;
   logic              req_ready;
   logic [AW-1:0]     req_rs;
   logic [AW-1:0]     req_rt;
   logic              req_dst_en;
   logic [AW-1:0]     req_dst;
   logic              wb_en;
   logic [AW-1:0]     wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_rs_data;
   logic [DATA_W-1:0] out_rt_data;
   logic              out_dst_en;
   logic [AW-1:0]     out_dst;
   logic [CNT_W-1:0]  stall_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   regfile_reader #(
      .DATA_W(DATA_W),
      .NREG  (NREG),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .regs       (regs),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rs     (req_rs),
      .req_rt     (req_rt),
      .req_dst_en (req_dst_en),
      .req_dst    (req_dst),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rs_data(out_rs_data),
      .out_rt_data(out_rt_data),
      .out_dst_en (out_dst_en),
      .out_dst    (out_dst),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic den, input logic [AW-1:0] d);
      req_valid  = 1'b1;
      req_rs     = rs;
      req_rt     = rt;
      req_dst_en = den;
      req_dst    = d;
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) regs[i] = '0;
      rst_n = 1'b0; req_valid = 1'b0; req_rs = '0; req_rt = '0;
      req_dst_en = 1'b0; req_dst = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      out_ready = 1'b1;
      regs[5]  = 32'h1111_0005;
      regs[9]  = 32'hABCD_0009;
      regs[0]  = 32'hFFFF_FFFF;
      regs[10] = 32'h0000_000A;

      // Reset state
      tick(); tick();
      req(5'd5, 5'd9, 1'b0, 5'd0);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_rs", out_rs_data, 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      tick();
      rst_n = 1'b1;

      // Plain read
      #1;
      chk("t1_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_rs", out_rs_data, 32'h1111_0005);
      chk("t1_rt", out_rt_data, 32'hABCD_0009);
      chk("t1_stall", 32'(stall_cnt), 32'd0);

      // Register zero
      req(5'd0, 5'd0, 1'b1, 5'd0);
      tick();
      chk("t2_rs", out_rs_data, 32'd0);
      chk("t2_rt", out_rt_data, 32'd0);
      chk("t2_dst_en", 32'(out_dst_en), 32'd1);
      req(5'd0, 5'd0, 1'b0, 5'd0);
      #1;
      chk("t2_r0_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;

      // Hazard plus bypass
      req(5'd1, 5'd2, 1'b1, 5'd7);
      tick();
      req(5'd7, 5'd0, 1'b0, 5'd0);
      #1;
      chk("t3_stalled", 32'(req_ready), 32'd0);
      tick(); tick(); tick();
      chk("t3_stall3", 32'(stall_cnt), 32'd3);
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0077;
      #1;
      chk("t3_release", 32'(req_ready), 32'd1);
      tick();
      wb_en = 1'b0;
      chk("t3_bypass", out_rs_data, 32'h0000_0077);
      chk("t3_valid", 32'(out_valid), 32'd1);

      // Backpressure, then drain and reload on the same edge
      out_ready = 1'b0;
      req(5'd9, 5'd5, 1'b0, 5'd0);
      #1;
      chk("t4_bp_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_hold_rs", out_rs_data, 32'h0000_0077);
         chk("t4_hold_valid", 32'(out_valid), 32'd1);
      end
      chk("t4_stall7", 32'(stall_cnt), 32'd7);
      out_ready = 1'b1;
      #1;
      chk("t4_drain_ready", 32'(req_ready), 32'd1);
      tick();
      chk("t4_reload_rs", out_rs_data, 32'hABCD_0009);
      chk("t4_reload_rt", out_rt_data, 32'h1111_0005);
      chk("t4_reload_valid", 32'(out_valid), 32'd1);

      // Set/clear collision on register 3
      req(5'd0, 5'd0, 1'b1, 5'd3);
      tick();
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0033;
      req(5'd0, 5'd0, 1'b1, 5'd3);
      #1;
      chk("t5_coll_ready", 32'(req_ready), 32'd1);
      tick();
      wb_en = 1'b0;
      chk("t5_dst", 32'(out_dst), 32'd3);
      req(5'd3, 5'd0, 1'b0, 5'd0);
      #1;
      chk("t5_still_busy", 32'(req_ready), 32'd0);
      tick();
      chk("t5_stall8", 32'(stall_cnt), 32'd8);
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0033;
      tick();
      wb_en = 1'b0;
      chk("t5_bypass", out_rs_data, 32'h0000_0033);

      // Saturation, then reset while output is held
      req(5'd5, 5'd9, 1'b1, 5'd10);
      tick();
      out_ready = 1'b0;
      req(5'd10, 5'd0, 1'b0, 5'd0);
      for (int i = 0; i < 20; i++) tick();
      chk("t6_sat", 32'(stall_cnt), 32'd15);
      chk("t6_valid_held", 32'(out_valid), 32'd1);
      chk("t6_dst_held", 32'(out_dst), 32'd10);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_rs", out_rs_data, 32'd0);
      chk("t6_rst_rt", out_rt_data, 32'd0);
      chk("t6_rst_dst_en", 32'(out_dst_en), 32'd0);
      chk("t6_rst_dst", 32'(out_dst), 32'd0);
      chk("t6_rst_stall", 32'(stall_cnt), 32'd0);
      chk("t6_rst_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("t6_busy_cleared", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      chk("t6_post_rs", out_rs_data, 32'h0000_000A);
      chk("t6_post_valid", 32'(out_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end

endmodule
